// File: rtl/md_issue.sv
// md_issue - E-stage issue and interlock controller for the multiply/divide unit.
//
// Latches the MD-class op decoded in D into a local E slot, issues it to MD
// (start/MDop/HIwrite/LOwrite), mirrors MD's busy window with a countdown and
// holds any MD-class instruction in D until HI/LO are committed.
//
// Optional feature macro: MD_MADD_EN (class 5 = madd legal when defined;
// otherwise class 5 is treated as none).
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   D_mdcls  in   [3:0] MD class of the D instruction (10..15 = none)
//   E_clr    in   flush the E slot
//   stall    out  freeze PC and F/D, bubble into D/E
//   start    out  one-cycle issue pulse to MD
//   MDop     out  [2:0] MD opcode, valid with start, else 000
//   HIwrite  out  mthi in E
//   LOwrite  out  mtlo in E
//   mfsel    out  [1:0] E result select: 00 ALU, 01 HI, 10 LO
//   busy     out  local mirror of MD busy (cnt != 0)

module md_issue #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] D_mdcls,
  input  logic       E_clr,
  output logic       stall,
  output logic       start,
  output logic [2:0] MDop,
  output logic       HIwrite,
  output logic       LOwrite,
  output logic [1:0] mfsel,
  output logic       busy
);

`ifdef MD_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] E_cls_q, E_cls_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] d_cls;
  logic       d_is_md;
  logic       e_mul;
  logic       e_div;
  logic [3:0] e_idx;

  // Canonical D class: anything outside 1..9 (and madd when disabled) is none,
  // so it neither stalls nor reaches the E slot.
  always_comb begin
    d_cls = '0;
    if (D_mdcls >= 4'd1 && D_mdcls <= 4'd9) begin
      d_cls = D_mdcls;
    end
    if (!MADD_EN && D_mdcls == 4'd5) begin
      d_cls = '0;
    end
    d_is_md = (d_cls != 4'd0);
  end

  // E-slot decode
  always_comb begin
    e_mul   = (E_cls_q == 4'd1) || (E_cls_q == 4'd2) || (E_cls_q == 4'd5);
    e_div   = (E_cls_q == 4'd3) || (E_cls_q == 4'd4);
    start   = e_mul || e_div;
    // Classes 1..5 map to MDop 000..100 in order.
    e_idx   = E_cls_q - 4'd1;
    MDop    = start ? e_idx[2:0] : 3'b000;
    HIwrite = (E_cls_q == 4'd8);
    LOwrite = (E_cls_q == 4'd9);
    mfsel   = 2'b00;
    if (E_cls_q == 4'd6) begin
      mfsel = 2'b01;
    end else if (E_cls_q == 4'd7) begin
      mfsel = 2'b10;
    end
    busy    = (cnt_q != 4'd0);
    stall   = d_is_md && (start || busy);
  end

  // Next state, counter and E slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (e_mul) begin
          state_d = S_MUL;
        end else if (e_div) begin
          state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cnt_d = cnt_q;
    if (start) begin
      cnt_d = (state_d == S_DIV) ? 4'(DIV_CYC) : 4'(MUL_CYC);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    E_cls_d = d_cls;
    if (E_clr || stall) begin
      E_cls_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      E_cls_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      E_cls_q <= E_cls_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_issue.sv
module tb_md_issue;

  logic       clk;
  logic       reset;
  logic [3:0] D_mdcls;
  logic       E_clr;
  logic       stall;
  logic       start;
  logic [2:0] MDop;
  logic       HIwrite;
  logic       LOwrite;
  logic [1:0] mfsel;
  logic       busy;

  int vec;
  int miss;

  // Output bundle: [9] stall [8] start [7:5] MDop [4] HIwrite [3] LOwrite [2:1] mfsel [0] busy
  logic [9:0] obs;
  assign obs = {stall, start, MDop, HIwrite, LOwrite, mfsel, busy};

  md_issue #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .D_mdcls (D_mdcls),
    .E_clr   (E_clr),
    .stall   (stall),
    .start   (start),
    .MDop    (MDop),
    .HIwrite (HIwrite),
    .LOwrite (LOwrite),
    .mfsel   (mfsel),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; D_mdcls = 4'd6; E_clr = 1'b0;
    #3;
    vec++;
    if (obs !== 10'b0) begin
      miss++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'b0);
    end
    tick(); tick();
    reset = 1'b0; D_mdcls = 4'd0;
    tick();
    vec++;
    if (obs !== 10'b0 || dut.cnt_q !== 4'd0) begin
      miss++; $display("FAIL reset_release got=%b cnt=%0d exp=%b cnt=0", obs, dut.cnt_q, 10'b0);
    end
  endtask

  task automatic test_mult_mflo();
    int stalls;
    stalls = 0;
    D_mdcls = 4'd2; #1;
    vec++;
    if (obs !== 10'b0) begin
      miss++; $display("FAIL mult_in_D got=%b exp=%b", obs, 10'b0);
    end
    tick();
    D_mdcls = 4'd7; #1;
    vec++;
    if (obs !== 10'b1_1_001_0_0_00_0) begin
      miss++; $display("FAIL mult_issue got=%b exp=%b", obs, 10'b1_1_001_0_0_00_0);
    end
    if (stall) stalls++;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vec++;
      if (obs !== 10'b1_0_000_0_0_00_1 || dut.cnt_q !== 4'(6 - k)) begin
        miss++; $display("FAIL mult_busy_%0d got=%b cnt=%0d exp=%b cnt=%0d", k, obs, dut.cnt_q, 10'b1_0_000_0_0_00_1, 6 - k);
      end
      if (stall) stalls++;
    end
    tick();
    vec++;
    if (obs !== 10'b0 || stalls != 6) begin
      miss++; $display("FAIL mult_release got=%b stalls=%0d exp=%b stalls=6", obs, stalls, 10'b0);
    end
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_0_000_0_0_10_0) begin
      miss++; $display("FAIL mflo_in_E got=%b exp=%b", obs, 10'b0_0_000_0_0_10_0);
    end
    tick();
  endtask

  task automatic test_divu_mfhi();
    D_mdcls = 4'd3;
    tick();
    D_mdcls = 4'd6; #1;
    vec++;
    if (obs !== 10'b1_1_010_0_0_00_0) begin
      miss++; $display("FAIL divu_issue got=%b exp=%b", obs, 10'b1_1_010_0_0_00_0);
    end
    tick();
    vec++;
    if (dut.cnt_q !== 4'd10) begin
      miss++; $display("FAIL divu_cnt_load got=%0d exp=10", dut.cnt_q);
    end
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      vec++;
      if (obs !== 10'b1_0_000_0_0_00_1) begin
        miss++; $display("FAIL divu_busy_%0d got=%b exp=%b", k, obs, 10'b1_0_000_0_0_00_1);
      end
    end
    tick();
    vec++;
    if (obs !== 10'b0) begin
      miss++; $display("FAIL divu_release got=%b exp=%b", obs, 10'b0);
    end
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_0_000_0_0_01_0) begin
      miss++; $display("FAIL mfhi_in_E got=%b exp=%b", obs, 10'b0_0_000_0_0_01_0);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    D_mdcls = 4'd8;
    tick();
    D_mdcls = 4'd9; #1;
    vec++;
    if (obs !== 10'b0_0_000_1_0_00_0) begin
      miss++; $display("FAIL b2b_mthi got=%b exp=%b", obs, 10'b0_0_000_1_0_00_0);
    end
    tick();
    D_mdcls = 4'd6; #1;
    vec++;
    if (obs !== 10'b0_0_000_0_1_00_0) begin
      miss++; $display("FAIL b2b_mtlo got=%b exp=%b", obs, 10'b0_0_000_0_1_00_0);
    end
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_0_000_0_0_01_0) begin
      miss++; $display("FAIL b2b_mfhi got=%b exp=%b", obs, 10'b0_0_000_0_0_01_0);
    end
    tick();
  endtask

  task automatic test_flush();
    // mult in E, div waiting in D, flush in the last stall cycle
    D_mdcls = 4'd2;
    tick();
    D_mdcls = 4'd4; #1;
    vec++;
    if (obs !== 10'b1_1_001_0_0_00_0) begin
      miss++; $display("FAIL flush_mult_issue got=%b exp=%b", obs, 10'b1_1_001_0_0_00_0);
    end
    for (int k = 1; k <= 5; k++) tick();
    E_clr = 1'b1; #1;
    vec++;
    if (obs !== 10'b1_0_000_0_0_00_1) begin
      miss++; $display("FAIL flush_last_stall got=%b exp=%b", obs, 10'b1_0_000_0_0_00_1);
    end
    tick();
    E_clr = 1'b0; #1;
    vec++;
    if (obs !== 10'b0) begin
      miss++; $display("FAIL flush_no_issue got=%b exp=%b", obs, 10'b0);
    end
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_1_011_0_0_00_0) begin
      miss++; $display("FAIL flush_div_issue got=%b exp=%b", obs, 10'b0_1_011_0_0_00_0);
    end
    tick();
    vec++;
    if (dut.cnt_q !== 4'd10 || busy !== 1'b1) begin
      miss++; $display("FAIL flush_div_cnt got=%0d busy=%b exp=10 busy=1", dut.cnt_q, busy);
    end
    for (int k = 1; k <= 10; k++) tick();
    // flush coincident with start: op still issues
    D_mdcls = 4'd1;
    tick();
    D_mdcls = 4'd0; E_clr = 1'b1; #1;
    vec++;
    if (obs !== 10'b0_1_000_0_0_00_0) begin
      miss++; $display("FAIL clr_with_start got=%b exp=%b", obs, 10'b0_1_000_0_0_00_0);
    end
    tick();
    E_clr = 1'b0; #1;
    vec++;
    if (dut.cnt_q !== 4'd5) begin
      miss++; $display("FAIL clr_with_start_cnt got=%0d exp=5", dut.cnt_q);
    end
    for (int k = 1; k <= 5; k++) tick();
    // flush with no stall blocks the load
    D_mdcls = 4'd8; E_clr = 1'b1;
    tick();
    D_mdcls = 4'd0; E_clr = 1'b0; #1;
    vec++;
    if (obs !== 10'b0) begin
      miss++; $display("FAIL clr_blocks_load got=%b exp=%b", obs, 10'b0);
    end
    tick();
  endtask

  task automatic test_madd();
    D_mdcls = 4'd2;
    tick();
    D_mdcls = 4'd5; #1;
`ifdef MD_MADD_EN
    vec++;
    if (obs !== 10'b1_1_001_0_0_00_0) begin
      miss++; $display("FAIL madd_wait_issue got=%b exp=%b", obs, 10'b1_1_001_0_0_00_0);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      vec++;
      if (obs !== 10'b1_0_000_0_0_00_1) begin
        miss++; $display("FAIL madd_stall_%0d got=%b exp=%b", k, obs, 10'b1_0_000_0_0_00_1);
      end
    end
    tick();
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_1_100_0_0_00_0) begin
      miss++; $display("FAIL madd_issue got=%b exp=%b", obs, 10'b0_1_100_0_0_00_0);
    end
    for (int k = 1; k <= 6; k++) tick();
`else
    vec++;
    if (obs !== 10'b0_1_001_0_0_00_0) begin
      miss++; $display("FAIL madd_off_no_stall got=%b exp=%b", obs, 10'b0_1_001_0_0_00_0);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      vec++;
      if (obs !== ((k <= 5) ? 10'b0_0_000_0_0_00_1 : 10'b0)) begin
        miss++; $display("FAIL madd_off_%0d got=%b exp=%b", k, obs, ((k <= 5) ? 10'b0_0_000_0_0_00_1 : 10'b0));
      end
    end
    D_mdcls = 4'd0;
    tick();
`endif
  endtask

  task automatic test_reset_mid_div();
    D_mdcls = 4'd4;
    tick();
    D_mdcls = 4'd0;
    tick();
    for (int k = 1; k <= 4; k++) tick();
    vec++;
    if (dut.cnt_q !== 4'd6) begin
      miss++; $display("FAIL rst_div_cnt got=%0d exp=6", dut.cnt_q);
    end
    D_mdcls = 4'd6;
    #2 reset = 1'b1;
    #1;
    vec++;
    if (obs !== 10'b0 || dut.cnt_q !== 4'd0) begin
      miss++; $display("FAIL rst_div_async got=%b cnt=%0d exp=%b cnt=0", obs, dut.cnt_q, 10'b0);
    end
    #2 reset = 1'b0;
    #1;
    vec++;
    if (stall !== 1'b0) begin
      miss++; $display("FAIL rst_div_mfhi_stall got=%b exp=0", stall);
    end
    tick();
    D_mdcls = 4'd0; #1;
    vec++;
    if (obs !== 10'b0_0_000_0_0_01_0) begin
      miss++; $display("FAIL rst_div_mfhi_E got=%b exp=%b", obs, 10'b0_0_000_0_0_01_0);
    end
    tick();
  endtask

  task automatic test_invalid_class();
    D_mdcls = 4'd2;
    tick();
    D_mdcls = 4'd12; #1;
    vec++;
    if (stall !== 1'b0) begin
      miss++; $display("FAIL invalid_no_stall got=%b exp=0", stall);
    end
    tick();
    vec++;
    if (obs !== 10'b0_0_000_0_0_00_1) begin
      miss++; $display("FAIL invalid_loads_none got=%b exp=%b", obs, 10'b0_0_000_0_0_00_1);
    end
    D_mdcls = 4'd0;
    for (int k = 1; k <= 6; k++) tick();
  endtask

  initial begin
    vec = 0; miss = 0;
    reset = 1'b1; D_mdcls = 4'd0; E_clr = 1'b0;
    test_reset();
    test_mult_mflo();
    test_divu_mfhi();
    test_back_to_back();
    test_flush();
    test_madd();
    test_reset_mid_div();
    test_invalid_class();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
